lsp_expand_1_pipe: RTL and testbench

Enforces the G.729 minimum spacing rule (Lsp_expand_1) on the lower half, indices 0..4, of the 10-entry LSP buffer held in scratch memory. It is the companion of the upper-half expander (indices 5..9). Both operate in place on the same buffer inside the Relspwed LSP quantizer path. The block is a bus master on the scratch memory controller: it reads two adjacent coefficients, computes the spread, and writes both back when they are too close.

---
 rtl/lsp_expand_1_pipe.sv | 162 ++++++++++++++++
 tb/tb_lsp_expand_1_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsp_expand_1_pipe.sv
// Lower-half LSP minimum-spacing expander (entries 0..NC-1), working in place
// on the scratch-memory LSP buffer through a read/compare/write-back FSM.
module lsp_expand_1_pipe #(
  parameter logic [11:0] BUF_BASE = 12'h3A0,
  parameter int          NC       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] gap,
  input  logic [31:0] memIn,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {IDLE, RDA, RDB, CAP, CALC, WRA, WRB, DONE} state_t;

  state_t state, nextState;
  logic [3:0] j;
  logic [3:0] jm1;
  logic       startAcc;
  logic       advance;
  logic       lastJ;

  logic signed [DATA_W-1:0] gap_p0;
  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  logic signed [DATA_W-1:0] tmp_p2;
  logic signed [DATA_W-1:0] diffC;
  logic signed [DATA_W-1:0] tmpC;
  logic signed [DATA_W-1:0] wrA;
  logic signed [DATA_W-1:0] wrB;
  logic                     posC;
  logic                     unusedMemHi;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] x);
    if (x > 17'sd32767)
      return 16'sh7FFF;
    else if (x < -17'sd32768)
      return 16'sh8000;
    else
      return $signed(x[DATA_W-1:0]);
  endfunction

  function automatic logic signed [DATA_W-1:0] add16(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] y);
    return sat16($signed({x[DATA_W-1], x}) + $signed({y[DATA_W-1], y}));
  endfunction

  function automatic logic signed [DATA_W-1:0] sub16(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] y);
    return sat16($signed({x[DATA_W-1], x}) - $signed({y[DATA_W-1], y}));
  endfunction

  function automatic logic signed [DATA_W-1:0] shr1(input logic signed [DATA_W-1:0] x);
    return x >>> 1;
  endfunction

  assign unusedMemHi = ^memIn[31:16];
  assign jm1         = j - 4'd1;
  assign lastJ       = (j == 4'(NC - 1));

  assign diffC = sub16(a_p1, b_p1);
  assign tmpC  = shr1(add16(diffC, gap_p0));
  assign posC  = (tmpC > 16'sd0);
  assign wrA   = sub16(a_p1, tmp_p2);
  assign wrB   = add16(b_p1, tmp_p2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      j     <= 4'd1;
    end else begin
      state <= nextState;
      if (startAcc)
        j <= 4'd1;
      else if (advance)
        j <= j + 4'd1;
    end
  end

  // Operand capture: a from the RDA read, b from the RDB read, tmp in CALC
  always_ff @(posedge clk) begin
    if (startAcc)
      gap_p0 <= $signed(gap);
    if (state == RDB)
      a_p1 <= $signed(memIn[DATA_W-1:0]);
    if (state == CAP)
      b_p1 <= $signed(memIn[DATA_W-1:0]);
    if (state == CALC)
      tmp_p2 <= tmpC;
  end

  always_comb begin
    nextState    = state;
    memReadAddr  = 12'd0;
    memWriteAddr = 12'd0;
    memOut       = 32'd0;
    memWriteEn   = 1'b0;
    done         = 1'b0;
    startAcc     = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          startAcc  = 1'b1;
          nextState = RDA;
        end
      end
      RDA: begin
        memReadAddr = {BUF_BASE[11:4], jm1};
        nextState   = RDB;
      end
      RDB: begin
        memReadAddr = {BUF_BASE[11:4], j};
        nextState   = CAP;
      end
      CAP: nextState = CALC;
      CALC: begin
        if (posC)
          nextState = WRA;
        else if (lastJ)
          nextState = DONE;
        else begin
          advance   = 1'b1;
          nextState = RDA;
        end
      end
      WRA: begin
        memWriteAddr = {BUF_BASE[11:4], jm1};
        memOut       = {{(32-DATA_W){wrA[DATA_W-1]}}, wrA};
        memWriteEn   = 1'b1;
        nextState    = WRB;
      end
      WRB: begin
        memWriteAddr = {BUF_BASE[11:4], j};
        memOut       = {{(32-DATA_W){wrB[DATA_W-1]}}, wrB};
        memWriteEn   = 1'b1;
        if (lastJ)
          nextState = DONE;
        else begin
          advance   = 1'b1;
          nextState = RDA;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          startAcc  = 1'b1;
          nextState = RDA;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsp_expand_1_pipe.sv
// Randomized bench for lsp_expand_1_pipe with a scratch-memory model and an
// integer reference of the spacing rule.
module tb_lsp_expand_1_pipe;

  localparam logic [11:0] BASE = 12'h3A0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gapIn = 16'd0;
  logic [31:0] memIn;
  logic [11:0] memReadAddr;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
  logic        done;

  logic [31:0] mem [16];
  logic [31:0] loadImg [16];
  logic        loadReq = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int stim [5];
  int refBuf [5];

  lsp_expand_1_pipe #(.BUF_BASE(BASE), .NC(5)) dut (
    .clk(clk), .reset(reset), .start(start), .gap(gapIn), .memIn(memIn),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
    .memWriteEn(memWriteEn), .done(done)
  );

  always #5 clk = ~clk;

  // Scratch memory: registered read, write committed at the strobed edge
  always @(posedge clk) begin
    memIn <= mem[memReadAddr[3:0]];
    if (loadReq) begin
      for (int i = 0; i < 16; i++) mem[i] <= loadImg[i];
    end else if (memWriteEn) begin
      mem[memWriteAddr[3:0]] <= memOut;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [31:0] marker(input int i);
    return 32'(32'h1111 * (i - 4));
  endfunction

  task automatic refModel(input int g, output int n);
    int a, b, t;
    n = 0;
    for (int k = 1; k < 5; k++) begin
      a = refBuf[k-1];
      b = refBuf[k];
      t = clamp16(clamp16(a - b) + g);
      t = (t < 0) ? -((-t + 1) / 2) : t / 2;
      if (t > 0) begin
        refBuf[k-1] = clamp16(a - t);
        refBuf[k]   = clamp16(b + t);
        n++;
      end
    end
  endtask

  task automatic loadBuf();
    for (int i = 0; i < 16; i++) begin
      if (i < 5) loadImg[i] = 32'(stim[i]);
      else if (i < 10) loadImg[i] = marker(i);
      else loadImg[i] = 32'hDEAD0000 | 32'(i);
    end
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
  endtask

  task automatic runPass(input string tag, input int g, input bit busy);
    int n, cyc, wr;
    loadBuf();
    for (int i = 0; i < 5; i++) refBuf[i] = stim[i];
    refModel(g, n);
    gapIn = 16'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_doneClr"}, 32'(done), 32'd0);
    cyc = 0;
    wr  = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (memWriteEn === 1'b1) begin
        wr++;
        check({tag, "_wrAddr"},
              32'(memWriteAddr[11:4] == BASE[11:4] && memWriteAddr[3:0] < 4'd5), 32'd1);
      end
      if (busy && cyc == 2) begin
        start = 1'b1;
        gapIn = 16'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(16 + 2 * n));
    check({tag, "_writes"}, 32'(wr), 32'(2 * n));
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_buf%0d", tag, i), mem[i], (i < 5) ? 32'(refBuf[i]) : marker(i));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, mode, base, g;
    for (int i = 0; i < 16; i++) loadImg[i] = 32'd0;

    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(memWriteEn), 32'd0);
    check("rst_raddr", 32'(memReadAddr), 32'd0);
    check("rst_waddr", 32'(memWriteAddr), 32'd0);
    check("rst_mout", memOut, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_raddr", 32'(memReadAddr), 32'd0);

    stim = '{100, 300, 500, 700, 900};
    runPass("spaced", 10, 1'b0);
    stim = '{1000, 1005, 2000, 3000, 4000};
    runPass("onePair", 10, 1'b0);
    check("onePair_b0", mem[0], 32'd998);
    check("onePair_b1", mem[1], 32'd1007);
    stim = '{500, 500, 500, 500, 500};
    runPass("cascade", 10, 1'b0);
    check("cascade_b4", mem[4], 32'd509);
    stim = '{32767, -32768, 0, 100, 200};
    runPass("sat", 10, 1'b0);
    check("sat_b0", mem[0], 32'h00004000);
    check("sat_b1", mem[1], 32'hFFFFBFFF);
    stim = '{500, 500, 500, 500, 500};
    runPass("busyStart", 10, 1'b1);

    // Reset during the first write of a cascade pass
    stim = '{500, 500, 500, 500, 500};
    loadBuf();
    gapIn = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (memWriteEn !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("midRst_wraSeen", 32'(memWriteEn), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midRst_done", 32'(done), 32'd0);
    check("midRst_wen", 32'(memWriteEn), 32'd0);
    repeat (3) @(negedge clk);
    check("midRst_buf1", mem[1], 32'd500);
    reset = 1'b1;
    @(negedge clk);
    runPass("afterRst", 10, 1'b0);

    for (int r = 0; r < 24; r++) begin
      mode = int'($urandom_range(0, 2));
      g    = ($urandom_range(0, 1) == 0) ? 10 : 5;
      base = int'($urandom_range(0, 20000)) - 10000;
      for (int i = 0; i < 5; i++) begin
        case (mode)
          0:       stim[i] = base + i * int'($urandom_range(0, 12));
          1:       stim[i] = int'($signed(16'($urandom)));
          default: stim[i] = base + int'($urandom_range(0, 6));
        endcase
      end
      runPass($sformatf("rnd%0d", r), g, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
